// File: rtl/sw_debounce.sv
// Slide-switch conditioner: synchroniser, per-bit debounce, edge pulses
// and a valid/ready change-event record for downstream control.
module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_mask,
    output logic [WIDTH-1:0] evt_state,
    output logic             evt_overrun,
    input  logic             evt_ready
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] flip;
    logic [WIDTH-1:0] stable_nxt;
    logic             acc;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= sw;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // A bit flips on the last of DEBOUNCE_CYCLES consecutive disagreeing cycles.
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i] = (s[i] != sw_stable[i]) && (cnt[i] == CNT_MAX);
        end
    end

    assign stable_nxt = sw_stable ^ flip;
    assign acc        = evt_valid & evt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if ((s[i] == sw_stable[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_stable <= '0;
            sw_rise   <= '0;
            sw_fall   <= '0;
        end else begin
            sw_stable <= stable_nxt;
            sw_rise   <= flip & stable_nxt;
            sw_fall   <= flip & ~stable_nxt;
        end
    end

    // A fresh flip on an accepting edge starts a new record rather than merging.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid   <= 1'b0;
            evt_mask    <= '0;
            evt_state   <= '0;
            evt_overrun <= 1'b0;
        end else if (|flip) begin
            evt_valid <= 1'b1;
            evt_state <= stable_nxt;
            if (!evt_valid || acc) begin
                evt_mask    <= flip;
                evt_overrun <= 1'b0;
            end else begin
                evt_mask    <= evt_mask | flip;
                evt_overrun <= evt_overrun | (|(evt_mask & flip));
            end
        end else if (acc) begin
            evt_valid   <= 1'b0;
            evt_mask    <= '0;
            evt_overrun <= 1'b0;
        end
    end

endmodule
